pipeline_sequencer: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32I pipeline (F, D, X, M, W).
- Combines the hazard unit's load-use/writeback stall, the X-stage branch redirect and a multi-cycle data-memory handshake into per-stage register enables and bubble-inserts.
- Holds fetch off for a programmable number of cycles after reset.
- Detects data-memory timeouts.

---
 rtl/pipeline_pkg.sv | 49 ++++
 rtl/seq_perf_counters.sv | 40 ++++
 rtl/pipeline_sequencer.sv | 119 +++++++++++
 tb/tb_pipeline_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: sequencer FSM encoding, per-stage control bundle and opcodes used by the hazard unit.
package pipeline_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } seq_state_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic f_en;
    logic d_en;
    logic x_en;
    logic m_en;
    logic w_en;
    logic d_flush;
    logic x_flush;
    logic w_flush;
    logic pc_redirect;
  } seq_ctl_t;

  // Freeze F..M and drain a bubble into W while the data memory is busy.
  localparam seq_ctl_t CTL_MEM_BUBBLE = '{
    f_en: 1'b0, d_en: 1'b0, x_en: 1'b0, m_en: 1'b0, w_en: 1'b1,
    d_flush: 1'b0, x_flush: 1'b0, w_flush: 1'b1, pc_redirect: 1'b0
  };

  // Free-running decode once memory is satisfied; a taken branch beats a
  // stall because the stalled instruction is on the wrong path.
  function automatic seq_ctl_t run_ctl(input logic hz, input logic br);
    seq_ctl_t c;
    c = '0;
    if (br) begin
      c.f_en = 1'b1; c.d_en = 1'b1; c.x_en = 1'b1; c.m_en = 1'b1; c.w_en = 1'b1;
      c.d_flush = 1'b1; c.x_flush = 1'b1; c.pc_redirect = 1'b1;
    end else if (hz) begin
      c.x_en = 1'b1; c.m_en = 1'b1; c.w_en = 1'b1;
      c.x_flush = 1'b1;
    end else begin
      c.f_en = 1'b1; c.d_en = 1'b1; c.x_en = 1'b1; c.m_en = 1'b1; c.w_en = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/seq_perf_counters.sv
// Wrapping 32-bit event counters for the sequencer: one increment per flagged cycle,
// visible the cycle after the event; never stalls anything.
module seq_perf_counters (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall_inc,
  input  logic        flush_inc,
  input  logic        wait_inc,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count,
  output logic [31:0] perf_mem_wait_cycles
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic [31:0] wait_q, wait_d;

  always_comb begin
    stall_d = stall_q + {31'd0, stall_inc};
    flush_d = flush_q + {31'd0, flush_inc};
    wait_d  = wait_q + {31'd0, wait_inc};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
    end
  end

  assign perf_stall_cycles    = stall_q;
  assign perf_flush_count     = flush_q;
  assign perf_mem_wait_cycles = wait_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline; enables/flushes are combinational from state+inputs.
// Memory wait freezes F..M until ack; PIPELINE_SEQ_PERF_EN adds perf counter ports.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hz_stall,
  input  logic        x_branch_taken,
  input  logic        m_mem_req,
  input  logic        m_mem_ack,
  output logic        f_en,
  output logic        d_en,
  output logic        x_en,
  output logic        m_en,
  output logic        w_en,
  output logic        d_flush,
  output logic        x_flush,
  output logic        w_flush,
  output logic        pc_redirect,
  output logic        mem_error,
  output logic [1:0]  state
`ifdef PIPELINE_SEQ_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count,
  output logic [31:0] perf_mem_wait_cycles
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(MEM_TIMEOUT - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  seq_ctl_t         ctl;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = '0;
    case (state_q)
      HOLD: begin
        cnt_d = cnt_inc;
        if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (m_mem_req && !m_mem_ack) begin
          state_d = MEM_WAIT;
          ctl     = CTL_MEM_BUBBLE;
        end else begin
          ctl = run_ctl(hz_stall, x_branch_taken);
        end
      end
      MEM_WAIT: begin
        if (m_mem_ack) begin
          state_d = RUN;
          cnt_d   = '0;
          ctl     = run_ctl(hz_stall, x_branch_taken);
        end else begin
          ctl   = CTL_MEM_BUBBLE;
          cnt_d = cnt_inc;
          if (cnt_q == TO_LAST) state_d = HALT;
        end
      end
      default: begin
        // HALT: frozen until reset; counter holds its value.
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign f_en        = ctl.f_en;
  assign d_en        = ctl.d_en;
  assign x_en        = ctl.x_en;
  assign m_en        = ctl.m_en;
  assign w_en        = ctl.w_en;
  assign d_flush     = ctl.d_flush;
  assign x_flush     = ctl.x_flush;
  assign w_flush     = ctl.w_flush;
  assign pc_redirect = ctl.pc_redirect;
  // HALT is only reachable through a timeout, so the sticky flag is the state itself.
  assign mem_error   = (state_q == HALT);
  assign state       = state_q;

`ifdef PIPELINE_SEQ_PERF_EN
  seq_perf_counters u_perf (
    .clock                (clock),
    .reset_n              (reset_n),
    .stall_inc            ((state_q == RUN) && hz_stall && !ctl.f_en),
    .flush_inc            (ctl.pc_redirect),
    .wait_inc             (state_q == MEM_WAIT),
    .perf_stall_cycles    (perf_stall_cycles),
    .perf_flush_count     (perf_flush_count),
    .perf_mem_wait_cycles (perf_mem_wait_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: vector table plus hand-written reset/timeout sequences.
module tb_pipeline_sequencer;
  import pipeline_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       hz_stall = 1'b0, x_branch_taken = 1'b0, m_mem_req = 1'b0, m_mem_ack = 1'b0;
  logic       f_en, d_en, x_en, m_en, w_en, d_flush, x_flush, w_flush, pc_redirect, mem_error;
  logic [1:0] state;
`ifdef PIPELINE_SEQ_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count, perf_mem_wait_cycles;
  int unsigned m_stall = 0, m_flush = 0, m_wait = 0;
`endif

  always #5 clock = ~clock;

  pipeline_sequencer #(.RESET_HOLD_CYCLES(4), .MEM_TIMEOUT(8), .CNT_W(8)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .hz_stall       (hz_stall),
    .x_branch_taken (x_branch_taken),
    .m_mem_req      (m_mem_req),
    .m_mem_ack      (m_mem_ack),
    .f_en           (f_en),
    .d_en           (d_en),
    .x_en           (x_en),
    .m_en           (m_en),
    .w_en           (w_en),
    .d_flush        (d_flush),
    .x_flush        (x_flush),
    .w_flush        (w_flush),
    .pc_redirect    (pc_redirect),
    .mem_error      (mem_error),
    .state          (state)
`ifdef PIPELINE_SEQ_PERF_EN
    ,
    .perf_stall_cycles    (perf_stall_cycles),
    .perf_flush_count     (perf_flush_count),
    .perf_mem_wait_cycles (perf_mem_wait_cycles)
`endif
  );

  typedef struct packed {
    logic [4:0] en;   // f,d,x,m,w
    logic [2:0] fl;   // d,x,w flush
    logic       pcr;
    logic       err;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    logic  hz, br, req, ack;
    exp_t  e;
    string nm;
  } vec_t;

  localparam logic [4:0] ALL = 5'b11111, STL = 5'b00111, WB = 5'b00001, NONE = 5'b00000;
  localparam logic [2:0] NOF = 3'b000, BRF = 3'b110, XF = 3'b010, WF = 3'b001;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_chk = 0;
  vec_t tbl[15];

  function automatic exp_t mk(logic [4:0] en, logic [2:0] fl, logic pcr, logic err, logic [1:0] st);
    exp_t e;
    e.en = en; e.fl = fl; e.pcr = pcr; e.err = err; e.st = st;
    return e;
  endfunction

  task automatic compare(input string nm);
    exp_t e, a;
    n_chk++;
    if (sbq.size() == 0) begin
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
      return;
    end
    e = sbq.pop_front();
    a = mk({f_en, d_en, x_en, m_en, w_en}, {d_flush, x_flush, w_flush}, pc_redirect, mem_error, state);
    if (a === e) n_pass++;
    else $display("FAIL %s: got en=%b fl=%b pcr=%b err=%b st=%0d, want en=%b fl=%b pcr=%b err=%b st=%0d",
                  nm, a.en, a.fl, a.pcr, a.err, a.st, e.en, e.fl, e.pcr, e.err, e.st);
  endtask

  task automatic drive(input logic hz, input logic br, input logic req, input logic ack);
    hz_stall = hz; x_branch_taken = br; m_mem_req = req; m_mem_ack = ack;
  endtask

  task automatic expect_cycle(input logic hz, input exp_t e);
    sbq.push_back(e);
`ifdef PIPELINE_SEQ_PERF_EN
    if (e.st == RUN && hz && !e.en[4]) m_stall++;
    if (e.pcr) m_flush++;
    if (e.st == MEM_WAIT) m_wait++;
`else
    if (hz) begin end
`endif
  endtask

  task automatic step(input logic hz, input logic br, input logic req, input logic ack,
                      input exp_t e, input string nm);
    @(posedge clock); #1;
    drive(hz, br, req, ack);
    expect_cycle(hz, e);
    @(negedge clock);
    compare(nm);
  endtask

  // Release reset with the given inputs applied; four HOLD cycles, inputs ignored.
  task automatic release_hold(input logic hz, input logic br, input logic req);
    @(posedge clock); #1;
    reset_n = 1'b1;
    drive(hz, br, req, 1'b0);
    expect_cycle(1'b0, mk(NONE, NOF, 0, 0, HOLD));
    @(negedge clock);
    compare("hold_c0");
    for (int i = 1; i < 4; i++) step(hz, br, req, 1'b0, mk(NONE, NOF, 0, 0, HOLD), "hold_cn");
  endtask

`ifdef PIPELINE_SEQ_PERF_EN
  task automatic perf_check(input string nm);
    n_chk++;
    if (perf_stall_cycles == m_stall && perf_flush_count == m_flush && perf_mem_wait_cycles == m_wait)
      n_pass++;
    else $display("FAIL %s: got stall=%0d flush=%0d wait=%0d, want stall=%0d flush=%0d wait=%0d",
                  nm, perf_stall_cycles, perf_flush_count, perf_mem_wait_cycles, m_stall, m_flush, m_wait);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(ALL, NOF, 0, 0, RUN),      "run_idle"};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(STL, XF,  0, 0, RUN),      "stall"};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, mk(ALL, NOF, 0, 0, RUN),      "stall_release"};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, mk(ALL, BRF, 1, 0, RUN),      "br_over_stall"};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(ALL, BRF, 1, 0, RUN),      "branch"};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, mk(ALL, NOF, 0, 0, RUN),      "mem_1cyc"};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, mk(STL, XF,  0, 0, RUN),      "mem_1cyc_stall"};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, mk(WB,  WF,  0, 0, RUN),      "mw_br_0"};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, mk(WB,  WF,  0, 0, MEM_WAIT), "mw_br_1"};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, mk(WB,  WF,  0, 0, MEM_WAIT), "mw_br_2"};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, mk(ALL, BRF, 1, 0, MEM_WAIT), "mw_ack_br"};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(ALL, NOF, 0, 0, RUN),      "after_ack"};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, mk(WB,  WF,  0, 0, RUN),      "mw_hz_0"};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, mk(STL, XF,  0, 0, MEM_WAIT), "mw_ack_hz"};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(ALL, NOF, 0, 0, RUN),      "after_ack2"};

    // Reset state
    repeat (2) @(negedge clock);
    expect_cycle(1'b0, mk(NONE, NOF, 0, 0, HOLD));
    compare("reset");

    release_hold(1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) step(tbl[i].hz, tbl[i].br, tbl[i].req, tbl[i].ack, tbl[i].e, tbl[i].nm);

`ifdef PIPELINE_SEQ_PERF_EN
    @(posedge clock); #1;
    perf_check("perf_table");
`endif

    // Memory timeout: 8 MEM_WAIT cycles then sticky HALT
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(WB, WF, 0, 0, RUN), "to_enter");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, mk(WB, WF, 0, 0, MEM_WAIT), "to_wait");
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(NONE, NOF, 0, 1, HALT), "halt");
    step(1'b1, 1'b1, 1'b1, 1'b1, mk(NONE, NOF, 0, 1, HALT), "halt_sticky_ack");
    step(1'b0, 1'b0, 1'b0, 1'b0, mk(NONE, NOF, 0, 1, HALT), "halt_sticky_idle");

    @(posedge clock); #1;
    reset_n = 1'b0;
`ifdef PIPELINE_SEQ_PERF_EN
    m_stall = 0; m_flush = 0; m_wait = 0;
`endif
    #1;
    expect_cycle(1'b0, mk(NONE, NOF, 0, 0, HOLD));
    compare("halt_reset");
    release_hold(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, mk(ALL, NOF, 0, 0, RUN), "run_after_halt");

    // Asynchronous reset in the middle of a memory wait with a branch pending
    step(1'b0, 1'b1, 1'b1, 1'b0, mk(WB, WF, 0, 0, RUN), "mr_enter");
    step(1'b0, 1'b1, 1'b1, 1'b0, mk(WB, WF, 0, 0, MEM_WAIT), "mr_wait");
    @(posedge clock); #1;
`ifdef PIPELINE_SEQ_PERF_EN
    perf_check("perf_pre_reset");
`endif
    #2 reset_n = 1'b0;
`ifdef PIPELINE_SEQ_PERF_EN
    m_stall = 0; m_flush = 0; m_wait = 0;
`endif
    #1;
    expect_cycle(1'b0, mk(NONE, NOF, 0, 0, HOLD));
    compare("mid_wait_reset");
`ifdef PIPELINE_SEQ_PERF_EN
    perf_check("perf_after_reset");
`endif
    release_hold(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, mk(ALL, NOF, 0, 0, RUN), "run_no_stale_redirect");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
